serial_word_tx: RTL and testbench
=================================

# serial_word_tx

Parallel-in/serial-out serializer that feeds the serial input of the 4-bit left-shift register stage. Accepts a WIDTH-bit word over a valid/ready handshake and emits it MSB first, one bit per clock, so that after WIDTH shifts the downstream left-shift register holds the word in its original bit order. A one-cycle `last` strobe marks the final bit of each word. Back-to-back words stream with no idle bit between them.

## Interface

**Parameters**
- `WIDTH`, default 4: word length in bits; legal range 2..32.

**Ports**
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: asynchronous, active-low reset.
- `din`, input, WIDTH: parallel word to send.
- `din_valid`, input, 1: `din` is valid.
- `din_ready`, output, 1: the block accepts `din` on this cycle.
- `sout`, output, 1: serial data, MSB first. Connects to the downstream `sin`.
- `sout_valid`, output, 1: `sout` carries a data bit this cycle.
- `last`, output, 1: `sout` is bit 0 of the current word.
- `busy`, output, 1: a word is being shifted out.

## Operation

- **Reset.** `rst` low clears the state and outputs immediately, without waiting for a clock edge:
  - state = IDLE, shift register = 0, counter = 0;
  - `sout`=0, `sout_valid`=0, `last`=0, `busy`=0;
  - `din_ready`=0 while `rst` is low, and it goes to 1 in IDLE once reset is released.
- **Handshake.** A transfer occurs on a rising edge when `din_valid && din_ready`. `din` is sampled only at that edge. `din_valid` without `din_ready` has no effect, and the word is neither consumed nor latched.
- **FSM states and transitions:**
  - **IDLE**
    - `din_ready`=1.
    - On transfer: load `din` into `sreg`, set `cnt`=WIDTH-1, go to SHIFT.
  - **SHIFT**
    - `sout`=`sreg[WIDTH-1]`, `sout_valid`=1, `busy`=1.
    - `last`=1 only when `cnt`==0.
    - `din_ready`=(`cnt`==0).
    - Each edge with `cnt`≠0: `sreg` <= {`sreg[WIDTH-2:0]`, 1'b0}, and `cnt` decrements.
    - Edge with `cnt`==0 and a transfer: reload `sreg`=`din` and `cnt`=WIDTH-1, and stay in SHIFT. This gives a gapless stream.
    - Edge with `cnt`==0 and no transfer: go to IDLE.
- **Output values.** In IDLE, `sout`=0, `sout_valid`=0 and `last`=0. `sout` never carries stale data.
- **Counter width.** `cnt` is $clog2(WIDTH) bits wide. It never wraps below 0, because the `cnt`==0 case always reloads or exits.
- **Reset mid-word.** The word in flight is discarded. No partial `last` strobe is produced.

## Timing

- All outputs are functions of registered state only. There is no combinational path from `din`/`din_valid` to any output.
- **Latency.** Word accepted at edge k:
  - MSB appears on `sout` in the cycle following edge k;
  - bit 0 appears after edge k+WIDTH-1, with `last`=1.
- **Throughput.** One word per WIDTH cycles when `din_valid` is held high.
- **Downstream alignment.** The downstream register (load=0) sampling `sout` on every edge where `sout_valid`=1 holds `din` exactly at the edge that consumes the `last` bit.

## Structure

- **Shared package** `serial_pkg`, holding:
  - state enum {IDLE, SHIFT};
  - `WIDTH_DEFAULT`=4, which is also shared with the left-shift register stage.
- **Sub-modules.** None are needed. This is a single module: FSM, `sreg` and down-counter, roughly 120–150 lines.

## Test plan

All scenarios use WIDTH=4.
- **Reset values.** Hold `rst`=0 for 2 cycles, then release -> `sout`=0, `sout_valid`=0, `last`=0, `busy`=0, `din_ready`=0 during reset and 1 after release.
- **Single word.** `din`=4'b1011 with `din_valid` for 1 cycle -> `sout`=1,0,1,1 on the next 4 cycles, `last` only on the 4th, then IDLE. A downstream left-shift register ends at q=4'b1011.
- **Back-to-back words.** `din_valid` held high with 4'b1100 then 4'b0110 -> 8 consecutive valid bits 1,1,0,0,0,1,1,0 with no gap. `din_ready` is high only on cycles 4 and 8, and `last` is high on cycles 4 and 8.
- **Held while busy.** `din_valid` held with 4'b1111 while in SHIFT at `cnt`=2 -> no transfer and `sreg` unchanged until the `cnt`==0 cycle, after which 4'b1111 is sent next.
- **Async reset mid-word.** Send 4'b1001 and pull `rst` low after the 2nd bit, between clock edges -> outputs clear immediately, no `last` pulse occurs, and the next word after release starts cleanly from its MSB.
- **Idle output.** No `din_valid` for 10 cycles -> `sout`=0, `sout_valid`=0 and `busy`=0 throughout.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial word transmitter and the left-shift register stage it feeds.
package serial_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/serial_word_tx.sv
// Parallel-in/serial-out word transmitter: accepts a word on valid/ready and shifts it out MSB first,
// with a one-cycle last strobe on bit 0 and gapless streaming of back-to-back words.
module serial_word_tx
  import serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy,
  output state_e           dbg_state
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  // Handshake: a word transfers on a rising edge where din_valid && din_ready are both high;
  // din is sampled only on that edge and din_valid alone never changes state.

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_zero;
  logic             transfer;

  assign cnt_zero = (cnt_q == '0);

  // Ready is held low for as long as reset is asserted, not just until the next edge.
  assign din_ready = rst && ((state_q == IDLE) || cnt_zero);
  assign transfer  = din_valid && din_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (transfer) begin
          sreg_d  = din;
          cnt_d   = CNT_LOAD;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!cnt_zero) begin
          sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
          cnt_d  = cnt_q - CNT_W'(1);
        end else if (transfer) begin
          sreg_d = din;
          cnt_d  = CNT_LOAD;
        end else begin
          sreg_d  = '0;
          state_d = IDLE;
        end
      end
      default: begin
        sreg_d  = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs depend on registered state only; IDLE forces the serial lane to zero.
  always_comb begin
    sout       = 1'b0;
    sout_valid = 1'b0;
    last       = 1'b0;
    busy       = 1'b0;
    if (state_q == SHIFT) begin
      sout       = sreg_q[WIDTH-1];
      sout_valid = 1'b1;
      last       = cnt_zero;
      busy       = 1'b1;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: word-level reference model with an expected-word queue, directed and random scenarios.
module tb_serial_word_tx;
  import serial_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         sout;
  logic         sout_valid;
  logic         last;
  logic         busy;
  state_e       dbg_state;

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of accepted words still being sent, and bits left of the head word.
  logic [W-1:0] exp_q[$];
  int           bits_left = 0;
  logic [W-1:0] ds_q = '0;

  serial_word_tx #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .sout      (sout),
    .sout_valid(sout_valid),
    .last      (last),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Downstream 4-bit left-shift register with load=0.
  always @(posedge clk) begin
    if (sout_valid) ds_q <= {ds_q[W-2:0], sout};
  end

  function automatic logic m_valid();
    return exp_q.size() > 0;
  endfunction

  function automatic logic m_sout();
    logic [W-1:0] h;
    if (exp_q.size() == 0) return 1'b0;
    h = exp_q[0];
    return h[bits_left-1];
  endfunction

  function automatic logic m_last();
    return (exp_q.size() > 0) && (bits_left == 1);
  endfunction

  function automatic logic m_ready();
    return rst && ((exp_q.size() == 0) || (bits_left == 1));
  endfunction

  function automatic logic [4:0] m_outs();
    return {m_valid(), m_sout(), m_last(), m_valid(), m_ready()};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    bits_left = 0;
  endtask

  // Drive one cycle from a falling edge, advance the model at the rising edge, return at the next falling edge.
  task automatic tick(input logic v, input logic [W-1:0] w);
    logic xfer;
    din_valid = v;
    din       = w;
    xfer      = v && m_ready();
    @(posedge clk);
    if (exp_q.size() > 0) begin
      bits_left--;
      if (bits_left == 0) exp_q.delete(0);
    end
    if (xfer) begin
      exp_q.push_back(w);
      if (exp_q.size() == 1) bits_left = W;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    din_valid = 1'b0;
    din       = '0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({sout_valid, sout, last, busy, din_ready} !== 5'b0) begin
      failures++;
      $display("FAIL reset_hold: v/s/l/b/r=%b want 00000", {sout_valid, sout, last, busy, din_ready});
    end
    checks++;
    if (dbg_state !== IDLE) begin
      failures++;
      $display("FAIL reset_state: state=%0d want IDLE", dbg_state);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({sout_valid, sout, last, busy, din_ready} !== 5'b00001) begin
      failures++;
      $display("FAIL reset_release: v/s/l/b/r=%b want 00001", {sout_valid, sout, last, busy, din_ready});
    end
    @(negedge clk);
  endtask

  task automatic test_single_word();
    logic [W-1:0] word = 4'b1011;
    tick(1'b1, word);
    for (int i = 0; i < W; i++) begin
      checks++;
      if ({sout_valid, sout, last, busy, din_ready} !== m_outs() ||
          sout !== word[W-1-i] || last !== (i == W - 1)) begin
        failures++;
        $display("FAIL single_bit%0d: v/s/l/b/r=%b want %b", i, {sout_valid, sout, last, busy, din_ready}, m_outs());
      end
      tick(1'b0, '0);
    end
    checks++;
    if (ds_q !== word || sout_valid !== 1'b0 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL single_downstream: ds=%b valid=%b want ds=%b valid=0", ds_q, sout_valid, word);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq = 8'b1100_0110;
    tick(1'b1, 4'b1100);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({sout_valid, sout, last, busy, din_ready} !== m_outs() || sout_valid !== 1'b1 ||
          sout !== seq[7-i] || din_ready !== (i == 3 || i == 7) || last !== (i == 3 || i == 7)) begin
        failures++;
        $display("FAIL b2b_bit%0d: v/s/l/b/r=%b want %b", i, {sout_valid, sout, last, busy, din_ready}, m_outs());
      end
      if (i < 4) tick(1'b1, 4'b0110);
      else       tick(1'b0, '0);
    end
  endtask

  task automatic test_held_while_busy();
    logic [7:0] seq = 8'b1010_1111;
    tick(1'b1, 4'b1010);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({sout_valid, sout, last, busy, din_ready} !== m_outs() ||
          sout !== seq[7-i] || din_ready !== (i == 3 || i == 7)) begin
        failures++;
        $display("FAIL held_bit%0d: v/s/l/b/r=%b want %b", i, {sout_valid, sout, last, busy, din_ready}, m_outs());
      end
      if (i >= 1 && i <= 3) tick(1'b1, 4'b1111);
      else                  tick(1'b0, '0);
    end
    checks++;
    if (ds_q !== 4'b1111 || busy !== 1'b0) begin
      failures++;
      $display("FAIL held_downstream: ds=%b busy=%b want ds=1111 busy=0", ds_q, busy);
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] word = 4'b0110;
    tick(1'b1, 4'b1001);
    tick(1'b0, '0);
    checks++;
    if (sout !== 1'b0 || sout_valid !== 1'b1 || last !== 1'b0) begin
      failures++;
      $display("FAIL arst_2nd_bit: s/v/l=%b%b%b want 010", sout, sout_valid, last);
    end
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({sout_valid, sout, last, busy, din_ready} !== 5'b0 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL arst_immediate: v/s/l/b/r=%b state=%0d want 00000 IDLE", {sout_valid, sout, last, busy, din_ready}, dbg_state);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 4'b1111);
      checks++;
      if (last !== 1'b0 || sout_valid !== 1'b0 || din_ready !== 1'b0) begin
        failures++;
        $display("FAIL arst_held%0d: l/v/r=%b%b%b want 000", i, last, sout_valid, din_ready);
      end
    end
    rst = 1'b1;
    tick(1'b1, word);
    for (int i = 0; i < W; i++) begin
      checks++;
      if ({sout_valid, sout, last, busy, din_ready} !== m_outs() || sout !== word[W-1-i]) begin
        failures++;
        $display("FAIL arst_next_bit%0d: v/s/l/b/r=%b want %b", i, {sout_valid, sout, last, busy, din_ready}, m_outs());
      end
      tick(1'b0, '0);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, W'($urandom_range(0, 15)));
      checks++;
      if (sout !== 1'b0 || sout_valid !== 1'b0 || busy !== 1'b0 || last !== 1'b0 || din_ready !== 1'b1) begin
        failures++;
        $display("FAIL idle_cycle%0d: s/v/b/l/r=%b%b%b%b%b want 00001", i, sout, sout_valid, busy, last, din_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] head;
    logic         was_last;
    for (int i = 0; i < 300; i++) begin
      checks++;
      if ({sout_valid, sout, last, busy, din_ready} !== m_outs()) begin
        failures++;
        $display("FAIL rand_cycle%0d: v/s/l/b/r=%b want %b", i, {sout_valid, sout, last, busy, din_ready}, m_outs());
      end
      was_last = m_last();
      head     = (exp_q.size() > 0) ? exp_q[0] : '0;
      tick($urandom_range(0, 3) != 0, W'($urandom_range(0, 15)));
      if (was_last) begin
        checks++;
        if (ds_q !== head) begin
          failures++;
          $display("FAIL rand_downstream%0d: ds=%b want %b", i, ds_q, head);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_held_while_busy();
    test_async_reset();
    test_idle();
    test_random();
    repeat (W + 1) tick(1'b0, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
